// File: rtl/mux3_bus_arbiter_pkg.sv
// Shared types and constants for the three-way round-robin bus arbiter.
package mux3_bus_arbiter_pkg;

  // Select code driven onto the 3:1 word mux; 2'd3 is never produced.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Result of a round-robin pick: whether anyone requested, and who won.
  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // Next requester in rotation order A -> B -> C -> A.
  function automatic sel_t sel_inc(input sel_t s);
    return (s == SEL_C) ? SEL_A : sel_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/mux3_bus_arbiter_if.sv
// Bundle of requester, downstream and status signals around the arbiter.
interface mux3_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  import mux3_bus_arbiter_pkg::*;

  logic [2:0]        req;
  logic [2:0]        last;
  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic [DATA_W-1:0] inC;
  logic              ack;
  sel_t              sel;
  logic [2:0]        grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  beat_cnt;

  // Arbiter side: consumes requests and ack, drives the shared path.
  modport slave (
    input  req, last, inA, inB, inC, ack,
    output sel, grant, out_valid, out_data, beat_cnt
  );

  // Environment side: requesters plus the downstream consumer.
  modport master (
    output req, last, inA, inB, inC, ack,
    input  sel, grant, out_valid, out_data, beat_cnt
  );

endinterface

// File: rtl/mux3_bus_arbiter_mux32.sv
// 32-bit 3:1 word select feeding the shared consumer port.
module mux3_bus_arbiter_mux32
  import mux3_bus_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  sel_t         sel,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic [W-1:0] out
);

  // Pure word select; the unused code 3 falls back to A.
  always_comb begin
    unique case (sel)
      SEL_B:   out = in_b;
      SEL_C:   out = in_c;
      default: out = in_a;
    endcase
  end

endmodule

// File: rtl/mux3_bus_arbiter.sv
// Round-robin owner of a shared 32-bit datapath for requesters A, B, C.
// A grant lasts until the owner's last beat, HOLD_MAX accepted beats, or the
// owner dropping its request; the next owner is picked in the same cycle.
module mux3_bus_arbiter
  import mux3_bus_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  mux3_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  state_e           state_q, state_d;
  sel_t             sel_q, sel_d;
  sel_t             ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic  own_req;
  logic  beat_acc;
  logic  hold_end;
  logic  release_now;
  sel_t  rel_ptr;
  sel_t  arb_ptr;
  pick_t win;

  // First asserted request scanning from ptr in rotation order.
  function automatic pick_t rr_pick(input logic [2:0] req, input sel_t ptr);
    pick_t p;
    sel_t  cand;
    p    = '0;
    cand = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
      cand = sel_inc(cand);
    end
    return p;
  endfunction

  // Handshake and release terms; re-arbitration starts past the owner on release.
  always_comb begin
    own_req     = bus.req[sel_q];
    beat_acc    = (state_q == BUSY) && own_req && bus.ack;
    hold_end    = (beat_cnt_q == CNT_W'(HOLD_MAX - 1));
    release_now = (state_q == BUSY) &&
                  (!own_req || (beat_acc && (bus.last[sel_q] || hold_end)));
    rel_ptr     = sel_inc(sel_q);
    arb_ptr     = release_now ? rel_ptr : ptr_q;
    win         = rr_pick(bus.req, arb_ptr);
  end

  // Next-state logic: grant from IDLE, hold/count in BUSY, hand over on release.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win.found) begin
          state_d    = BUSY;
          sel_d      = win.idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d      = rel_ptr;
          beat_cnt_d = '0;
          if (win.found) begin
            sel_d = win.idx;
          end else begin
            state_d = IDLE;
            sel_d   = SEL_A;
          end
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        sel_d      = SEL_A;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      state_q    <= IDLE;
      sel_q      <= SEL_A;
      ptr_q      <= SEL_A;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Status outputs decoded from the registered owner.
  always_comb begin
    bus.grant     = (state_q == BUSY) ? (3'b001 << sel_q) : 3'b000;
    bus.out_valid = (state_q == BUSY) && own_req;
    bus.sel       = sel_q;
    bus.beat_cnt  = beat_cnt_q;
  end

  mux3_bus_arbiter_mux32 #(
    .W (DATA_W)
  ) u_mux (
    .sel  (sel_q),
    .in_a (bus.inA),
    .in_b (bus.inB),
    .in_c (bus.inC),
    .out  (bus.out_data)
  );

endmodule
